// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: controller for a direct-mapped cache with one word per line.
// It owns the tag, valid and data arrays and serves one lookup at a time.
// A miss triggers a single-word refill from backing memory.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   req_valid/ready - lookup request handshake; req_addr is a byte address
//   flush           - one-cycle pulse that invalidates every line
//   resp_valid      - one-cycle response strobe; resp_hit/resp_data hold
//                     their values until the next response
//   mem_req_*       - refill read request to memory (word-aligned address)
//   mem_resp_*      - refill data from memory
//   busy            - FSM not idle, or a flush is waiting to execute
//   hit_count/miss_count - saturating response counters, only present when
//                     CACHE_STATS_EN is defined
//
// Handshake rule: a transfer happens on the rising edge where valid and
// ready are both high. Valid must not depend on ready. The payload stays
// stable while valid is high and ready is low. This applies to req_* and
// to mem_req_*.
//
// Optional feature macro: CACHE_STATS_EN.
// The FSM state is kept in r_state for observation.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
`ifdef CACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic              busy
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-3:0]   r_waddr;       // latched word address
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];
  logic                r_flush_pend;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic [DATA_W-1:0]   r_resp_data;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_accept;
  logic                w_flush_now;
  logic                w_hit_resp;
  logic                w_refill;
  logic                w_unused_ok;

  // The byte-offset bits never matter for a word-per-line cache.
  assign w_unused_ok = &{1'b1, req_addr[1:0]};

  assign w_idx = r_waddr[INDEX_W-1:0];
  assign w_tag = r_waddr[ADDR_W-3:INDEX_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A pending flush, or one arriving now, blocks new accepts in IDLE.
  // This guarantees that the flush executes before the next lookup.
  assign w_flush_now = (r_state == S_IDLE) && (flush || r_flush_pend);
  assign req_ready   = !rst && (r_state == S_IDLE) && !flush && !r_flush_pend;
  assign w_accept    = req_valid && req_ready;

  assign mem_req_valid = (r_state == S_MISS_REQ);
  assign mem_req_addr  = mem_req_valid ? {r_waddr, 2'b00} : '0;
  assign busy          = (r_state != S_IDLE) || r_flush_pend;

  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_data  = r_resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_hit_resp = 1'b0;
    w_refill   = 1'b0;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit) begin
          w_hit_resp = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_next = S_MISS_REQ;
        end
      end
      S_MISS_REQ:  if (mem_req_ready) w_next = S_MISS_WAIT;
      S_MISS_WAIT: begin
        if (mem_resp_valid) begin
          w_refill = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr      <= '0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept) r_waddr <= req_addr[ADDR_W-1:2];
      // Outside IDLE a flush is only remembered; it executes in IDLE.
      if (flush && (r_state != S_IDLE)) r_flush_pend <= 1'b1;
      else if (r_state == S_IDLE)       r_flush_pend <= 1'b0;
      if (w_flush_now)   r_valid        <= '0;
      else if (w_refill) r_valid[w_idx] <= 1'b1;
      r_resp_valid <= w_hit_resp || w_refill;
      if (w_hit_resp) begin
        r_resp_hit  <= 1'b1;
        r_resp_data <= r_data[w_idx];
      end else if (w_refill) begin
        r_resp_hit  <= 1'b0;
        r_resp_data <= mem_resp_data;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_resp_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_resp && (r_hit_count != 32'hFFFF_FFFF))
        r_hit_count <= r_hit_count + 32'd1;
      if (w_refill && (r_miss_count != 32'hFFFF_FFFF))
        r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl.
// Expected responses are queued as {hit, data} when a request is issued.
// A monitor pops and compares an entry on every resp_valid strobe.
// Timing-specific checks, such as refill address, stall, flush and reset,
// are made inline.
module tb_dm_cache_ctrl;

  localparam int W = 33;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dm_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
`ifdef CACHE_STATS_EN
    .hit_count      (hit_count),
    .miss_count     (miss_count),
`endif
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got hit=%b data=%h expected no response",
                 resp_hit, resp_data);
      end else begin
        chk("resp", {31'd0, resp_hit, resp_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_req(input logic [31:0] a);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic serve_req(input logic [31:0] a, input int stall);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mreq_seen", {63'd0, mem_req_valid}, 64'd1);
    chk("mreq_addr", {32'd0, mem_req_addr}, {32'd0, a});
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("stall_addr", {32'd0, mem_req_addr}, {32'd0, a});
      chk("stall_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mreq_drop", {63'd0, mem_req_valid}, 64'd0);
  endtask

  task automatic serve_resp(input logic [31:0] d);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic miss(input logic [31:0] a, input int stall, input logic [31:0] d);
    exp_q.push_back({1'b0, d});
    do_req(a);
    serve_req({a[31:2], 2'b00}, stall);
    serve_resp(d);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({1'b1, d});
    do_req(a);
    chk("hit_early", {63'd0, resp_valid}, 64'd0);
    chk("hit_no_mreq", {63'd0, mem_req_valid}, 64'd0);
    @(negedge clk);
    chk("hit_latency", {63'd0, resp_valid}, 64'd1);
    chk("hit_no_mreq2", {63'd0, mem_req_valid}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_mreq_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_mreq_addr", {32'd0, mem_req_addr}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1 chk("rdy_after_rst", {63'd0, req_ready}, 64'd1);
    @(negedge clk);

    // Cold miss on 0x14.
    miss(32'h14, 0, 32'hDEADBEEF);

    // Stray memory response while idle must be ignored.
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BAD0BAD;
    @(negedge clk);
    mem_resp_valid = 1'b0;

    // Hits on the same word, including a non-zero byte offset.
    hit(32'h14, 32'hDEADBEEF);
    hit(32'h16, 32'hDEADBEEF);

    // Conflict: 0x54 shares index 5 and evicts 0x14. Refill 0x14 with a stalled memory.
    miss(32'h54, 0, 32'h11111111);
    miss(32'h14, 3, 32'h22222222);
    hit(32'h14, 32'h22222222);

    // Flush arriving during MISS_WAIT waits until the refill completes.
    exp_q.push_back({1'b0, 32'h77777777});
    do_req(32'h40);
    serve_req(32'h40, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wait_busy", {63'd0, busy}, 64'd1);
    serve_resp(32'h77777777);
    chk("flush_pend_rdy", {63'd0, req_ready}, 64'd0);
    chk("flush_pend_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("flush_done_rdy", {63'd0, req_ready}, 64'd1);
    chk("flush_done_busy", {63'd0, busy}, 64'd0);
    miss(32'h14, 0, 32'h33333333);

    // Flush and request together in IDLE: flush wins, request goes next cycle.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h14;
    #1 chk("flush_vs_req_rdy", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    exp_q.push_back({1'b0, 32'h44444444});
    #1 chk("after_flush_rdy", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    serve_req(32'h14, 0);
    serve_resp(32'h44444444);

    // Reset during MISS_WAIT aborts the refill; the late memory data is ignored.
    do_req(32'h54);
    serve_req(32'h54, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_resp_hit", {63'd0, resp_hit}, 64'd0);
    chk("mid_rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("mid_rst_mreq", {63'd0, mem_req_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_rdy", {63'd0, req_ready}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h55555555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("mid_rst_no_resp", {63'd0, resp_valid}, 64'd0);
    rst = 1'b0;
    #1 chk("mid_rst_release_rdy", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    miss(32'h14, 0, 32'h66666666);
    hit(32'h14, 32'h66666666);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
